// File: rtl/logip_sampler_ctrl.sv
// Capture controller: ring-buffer writes while armed, post-trigger delay,
// then newest-first readback to the transmitter over a valid/ready handshake.
//
// state       | meaning
// S_IDLE      | waiting for arm_i
// S_ARMED     | pre-trigger capture into the ring buffer
// S_DELAY     | post-trigger capture, counting down delay samples
// S_READ_ADDR | read address on the RAM bus
// S_READ_WAIT | RAM data valid, loaded into tx_data_o
// S_SEND      | tx_stb_o held until the transmitter accepts
module logip_sampler_ctrl #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       cmd_i,
  input  logic              set_cnt_i,
  input  logic              arm_i,
  input  logic              run_i,
  input  logic              stb_i,
  input  logic [31:0]       smpls_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_din_o,
  input  logic [31:0]       mem_dout_i,
  output logic [31:0]       tx_data_o,
  output logic              tx_stb_o,
  input  logic              tx_rdy_i,
  output logic              busy_o
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_READ_ADDR,
    S_READ_WAIT,
    S_SEND
  } state_t;

  state_t            state;
  logic [15:0]       read_cnt;
  logic [15:0]       delay_cnt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [17:0]       dly_rem;
  logic [CNT_W-1:0]  rd_rem;
  logic              cap_done;
  logic [18:0]       read_len_raw;
  logic [18:0]       read_len;
  logic [17:0]       delay_len;

  assign read_len_raw = ({3'b000, read_cnt} + 19'd1) << 2;
  assign read_len     = (read_len_raw > 19'(DEPTH)) ? 19'(DEPTH) : read_len_raw;
  // 18-bit wrap is intentional: a field of 0xFFFF yields a length of 0
  assign delay_len    = ({2'b00, delay_cnt} + 18'd1) << 2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      read_cnt   <= '0;
      delay_cnt  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      dly_rem    <= '0;
      rd_rem     <= '0;
      cap_done   <= 1'b0;
      mem_addr_o <= '0;
      mem_we_o   <= 1'b0;
      mem_din_o  <= '0;
      tx_data_o  <= '0;
      tx_stb_o   <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      if (set_cnt_i) begin
        read_cnt  <= cmd_i[31:16];
        delay_cnt <= cmd_i[15:0];
      end
      mem_we_o <= 1'b0;

      case (state)
        S_IDLE: begin
          if (arm_i) begin
            state   <= S_ARMED;
            busy_o  <= 1'b1;
            dly_rem <= delay_len;
            rd_rem  <= CNT_W'(read_len);
          end
        end

        S_ARMED: begin
          if (stb_i) begin
            mem_we_o   <= 1'b1;
            mem_addr_o <= wr_ptr;
            mem_din_o  <= smpls_i;
            wr_ptr     <= wr_ptr + ADDR_W'(1);
          end
          if (run_i) begin
            state <= S_DELAY;
            if (stb_i) dly_rem <= dly_rem - 18'd1;
          end
        end

        S_DELAY: begin
          // One extra cycle lets the final write land before the bus turns to reads
          if (cap_done) begin
            cap_done   <= 1'b0;
            mem_addr_o <= rd_ptr;
            state      <= S_READ_ADDR;
          end else if (stb_i) begin
            mem_we_o   <= 1'b1;
            mem_addr_o <= wr_ptr;
            mem_din_o  <= smpls_i;
            wr_ptr     <= wr_ptr + ADDR_W'(1);
            dly_rem    <= dly_rem - 18'd1;
            if (dly_rem == 18'd1) begin
              rd_ptr   <= wr_ptr;
              cap_done <= 1'b1;
            end
          end
        end

        S_READ_ADDR: begin
          state <= S_READ_WAIT;
        end

        S_READ_WAIT: begin
          tx_data_o <= mem_dout_i;
          tx_stb_o  <= 1'b1;
          state     <= S_SEND;
        end

        S_SEND: begin
          if (tx_stb_o && tx_rdy_i) begin
            tx_stb_o <= 1'b0;
            rd_rem   <= rd_rem - CNT_W'(1);
            rd_ptr   <= rd_ptr - ADDR_W'(1);
            if (rd_rem == CNT_W'(1)) begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
            end else begin
              mem_addr_o <= rd_ptr - ADDR_W'(1);
              state      <= S_READ_ADDR;
            end
          end
        end

        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logip_sampler_ctrl.sv
// Directed bench for logip_sampler_ctrl with DEPTH=16 and a synchronous-read RAM model.
module tb_logip_sampler_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] cmd_i;
  logic        set_cnt_i;
  logic        arm_i;
  logic        run_i;
  logic        stb_i;
  logic [31:0] smpls_i;
  logic [3:0]  mem_addr_o;
  logic        mem_we_o;
  logic [31:0] mem_din_o;
  logic [31:0] mem_dout_i;
  logic [31:0] tx_data_o;
  logic        tx_stb_o;
  logic        tx_rdy_i;
  logic        busy_o;

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;
  int we0;
  logic [31:0] ram [16];
  logic [31:0] exp_q [$];

  always #5 clk_i = ~clk_i;

  logip_sampler_ctrl #(.DEPTH(16)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cmd_i      (cmd_i),
    .set_cnt_i  (set_cnt_i),
    .arm_i      (arm_i),
    .run_i      (run_i),
    .stb_i      (stb_i),
    .smpls_i    (smpls_i),
    .mem_addr_o (mem_addr_o),
    .mem_we_o   (mem_we_o),
    .mem_din_o  (mem_din_o),
    .mem_dout_i (mem_dout_i),
    .tx_data_o  (tx_data_o),
    .tx_stb_o   (tx_stb_o),
    .tx_rdy_i   (tx_rdy_i),
    .busy_o     (busy_o)
  );

  always @(posedge clk_i) begin
    if (mem_we_o === 1'b1) begin
      ram[mem_addr_o] <= mem_din_o;
      we_cnt <= we_cnt + 1;
    end
    mem_dout_i <= ram[mem_addr_o];
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [31:0] d, input logic r);
    stb_i = 1'b1; smpls_i = d; run_i = r;
    @(negedge clk_i);
    stb_i = 1'b0; run_i = 1'b0;
  endtask

  task automatic arm();
    arm_i = 1'b1;
    @(negedge clk_i);
    arm_i = 1'b0;
  endtask

  task automatic setcnt(input logic [31:0] c);
    cmd_i = c; set_cnt_i = 1'b1;
    @(negedge clk_i);
    set_cnt_i = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_tx_stb", 32'(tx_stb_o), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    rst_i = 1'b0;
  endtask

  // Accepts n words, stalling `stall` cycles per word; expected words come from exp_q.
  task automatic readback(input int n, input int stall);
    int got = 0;
    int cyc = 0;
    int wait_cnt = 0;
    int last_xfer = 0;
    logic [31:0] held = '0;
    tx_rdy_i = 1'b0;
    while (got < n && cyc < 400) begin
      @(negedge clk_i);
      cyc++;
      tx_rdy_i = 1'b0;
      if (tx_stb_o) begin
        if (wait_cnt == 0) begin
          chk("tx_word", tx_data_o, exp_q[got]);
          held = tx_data_o;
        end else begin
          chk("tx_hold", tx_data_o, held);
        end
        if (wait_cnt >= stall) begin
          if (stall == 0 && got > 0) chk("tx_spacing", 32'(cyc - last_xfer), 32'd3);
          last_xfer = cyc;
          tx_rdy_i = 1'b1;
          got++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else if (wait_cnt > 0) begin
        chk("tx_stb_hold", 32'(tx_stb_o), 32'd1);
      end
    end
    chk("tx_count", 32'(got), 32'(n));
    @(negedge clk_i);
    tx_rdy_i = 1'b0;
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("idle_tx_stb", 32'(tx_stb_o), 32'd0);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 16; i++) ram[i] = 32'hDEAD_0000 + 32'(i);
    rst_i = 1'b1; cmd_i = '0; set_cnt_i = 0; arm_i = 0; run_i = 0;
    stb_i = 0; smpls_i = '0; tx_rdy_i = 0;
    repeat (3) @(negedge clk_i);
    chk("reset_addr", 32'(mem_addr_o), 32'd0);
    chk("reset_we", 32'(mem_we_o), 32'd0);
    chk("reset_din", mem_din_o, 32'd0);
    chk("reset_tx_data", tx_data_o, 32'd0);
    chk("reset_tx_stb", 32'(tx_stb_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    rst_i = 1'b0;

    // Basic capture: delay 4, trigger on sample 6, read 4
    setcnt(32'h0000_0000);
    we0 = we_cnt;
    arm();
    chk("armed_busy", 32'(busy_o), 32'd1);
    for (int i = 0; i < 10; i++) strobe(32'(i), i == 6);
    exp_q = '{32'd9, 32'd8, 32'd7, 32'd6};
    readback(4, 0);
    chk("t1_writes", 32'(we_cnt - we0), 32'd10);

    // Ring wrap: 20 pre-trigger samples, delay 8, read 16 across the 0->15 boundary
    setcnt(32'h0003_0001);
    we0 = we_cnt;
    arm();
    for (int i = 0; i < 20; i++) strobe(32'(100 + i), 1'b0);
    run_i = 1'b1;
    @(negedge clk_i);
    run_i = 1'b0;
    for (int i = 0; i < 8; i++) strobe(32'(200 + i), 1'b0);
    exp_q = '{207, 206, 205, 204, 203, 202, 201, 200,
              119, 118, 117, 116, 115, 114, 113, 112};
    readback(16, 0);
    chk("t2_writes", 32'(we_cnt - we0), 32'd28);

    // Read-count clamp to DEPTH
    setcnt(32'hFFFF_0000);
    arm();
    for (int i = 0; i < 4; i++) strobe(32'(300 + i), i == 0);
    exp_q = '{303, 302, 301, 300, 207, 206, 205, 204,
              203, 202, 201, 200, 119, 118, 117, 116};
    readback(16, 0);

    // Backpressure: 5 stalled cycles per word
    setcnt(32'h0000_0000);
    arm();
    for (int i = 0; i < 4; i++) strobe(32'(400 + i), i == 0);
    exp_q = '{403, 402, 401, 400};
    readback(4, 5);

    // stb+run on the first armed cycle; mid-capture count update; stray strobe after capture
    we0 = we_cnt;
    arm();
    strobe(32'd500, 1'b1);
    cmd_i = 32'hFFFF_0003; set_cnt_i = 1'b1;
    strobe(32'd501, 1'b0);
    set_cnt_i = 1'b0;
    strobe(32'd502, 1'b0);
    strobe(32'd503, 1'b0);
    strobe(32'd504, 1'b0);
    exp_q = '{503, 502, 501, 500};
    readback(4, 0);
    chk("t5_writes", 32'(we_cnt - we0), 32'd4);

    // Reset in DELAY
    arm();
    strobe(32'd600, 1'b1);
    strobe(32'd601, 1'b0);
    pulse_reset();

    // Reset in SEND
    arm();
    for (int i = 0; i < 4; i++) strobe(32'(700 + i), i == 0);
    cyc = 0;
    while (tx_stb_o !== 1'b1 && cyc < 20) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("reach_send", 32'(tx_stb_o), 32'd1);
    pulse_reset();
    chk("rst_tx_data", tx_data_o, 32'd0);

    // Stray strobes and run while idle
    we0 = we_cnt;
    stb_i = 1'b1; run_i = 1'b1; smpls_i = 32'h5555_AAAA;
    repeat (3) @(negedge clk_i);
    stb_i = 1'b0; run_i = 1'b0;
    @(negedge clk_i);
    chk("idle_no_write", 32'(we_cnt - we0), 32'd0);
    chk("idle_stays", 32'(busy_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logip_sampler_ctrl.md
Name: logip_sampler_ctrl

Overview:
- Capture controller directly downstream of the trigger stage.
- While armed, writes every strobed sample into a ring buffer in external single-port RAM.
- After the trigger's run output asserts, captures a programmed number of post-trigger samples, then stops.
- Reads back a programmed number of samples, newest first, and hands them word-by-word to the transmitter over a valid/ready handshake.

Parameters:
DEPTH, 1024, ring buffer depth in 32-bit samples; power of two, >= 4
ADDR_W, $clog2(DEPTH), memory address width

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
cmd_i  in  32  command payload: [31:16] read count field, [15:0] delay count field
set_cnt_i  in  1  one-cycle pulse; latch cmd_i into the count registers
arm_i  in  1  one-cycle pulse; start a capture (same pulse that arms the trigger)
run_i  in  1  trigger fired (connected to trigger run output); level
stb_i  in  1  sample valid strobe, one cycle per sample
smpls_i  in  32  sample data, valid with stb_i
mem_addr_o  out  ADDR_W  RAM address
mem_we_o  out  1  RAM write enable
mem_din_o  out  32  RAM write data
mem_dout_i  in  32  RAM read data, valid one cycle after address is applied with we=0
tx_data_o  out  32  sample word to transmitter
tx_stb_o  out  1  tx_data_o valid; held until accepted
tx_rdy_i  in  1  transmitter ready; transfer when tx_stb_o && tx_rdy_i
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE; wr_ptr=0; count registers read_cnt=0, delay_cnt=0.
- Reset outputs: mem_addr_o=0, mem_we_o=0, mem_din_o=0, tx_data_o=0, tx_stb_o=0, busy_o=0.
- Reset mid-operation aborts any capture or readback. It drops tx_stb_o in the same cycle as the reset edge and returns to IDLE.
- Count decode:
  - read_len = min((cmd[31:16]+1)*4, DEPTH).
  - delay_len = (cmd[15:0]+1)*4, 18-bit arithmetic, no clamp.
  - set_cnt_i is accepted in any state. Values are snapshotted into working counters on IDLE->ARMED; a mid-capture update affects only the next capture.
- IDLE: arm_i -> ARMED; wr_ptr is kept, not cleared.
- ARMED:
  - On each stb_i: mem_we_o=1, mem_addr_o=wr_ptr, mem_din_o=smpls_i, wr_ptr increments modulo DEPTH (DEPTH-1 wraps to 0). The write is registered: RAM sees it the cycle after stb_i.
  - When run_i=1, go to DELAY.
  - If stb_i and run_i are both high in the same cycle, that sample is written and counts as delay sample 1.
- DELAY:
  - Writes continue exactly as in ARMED.
  - Each strobe decrements the remaining delay count.
  - On the strobe that brings the count to 0, the sample is written, last_ptr = that sample's address, and state -> READ_ADDR.
  - run_i and arm_i are ignored here.
- READ_ADDR: mem_we_o=0, mem_addr_o=rd_ptr (initially last_ptr) -> READ_WAIT.
- READ_WAIT: capture mem_dout_i into tx_data_o, tx_stb_o=1 -> SEND.
- SEND:
  - On tx_stb_o && tx_rdy_i: tx_stb_o=0, decrement remaining, rd_ptr decrements modulo DEPTH (0 wraps to DEPTH-1).
  - If remaining is now 0 -> IDLE, else -> READ_ADDR.
  - tx_data_o is stable while tx_stb_o=1 and unaccepted.
- Throughput: one word per 3 cycles when tx_rdy_i is held high.
- stb_i outside ARMED/DELAY: ignored, no write.
- arm_i outside IDLE: ignored.
- Readback of more words than were ever written returns stale RAM contents. No error flag is raised.
- mem_we_o is never asserted in READ_ADDR, READ_WAIT or SEND.

Test Plan:
- DEPTH=16, cmd=0x0000_0000 (read 4, delay 4); arm; 10 strobes with data 0..9; run_i at sample 6 -> writes addresses 0..9, stops after sample 9; tx sequence 9,8,7,6; returns to IDLE with busy_o=0.
- DEPTH=16, cmd=0x0003_0001 (read 16, delay 8); 20 pre-trigger strobes then trigger -> wr_ptr wraps; tx sends 16 words newest-first across the 0->15 address wrap, data equals last 16 written values.
- Read-count clamp: DEPTH=16, cmd=0xFFFF_0000 -> exactly 16 tx transfers.
- Backpressure: hold tx_rdy_i low 5 cycles per word -> tx_data_o and tx_stb_o stable while stalled; no word lost or duplicated.
- stb_i and run_i coincide on the first armed cycle with delay 4 -> that sample plus 3 more captured; readback newest = 4th sample.
- rst_i asserted in DELAY and again in SEND -> next cycle busy_o=0, tx_stb_o=0, mem_we_o=0. Stray stb_i and run_i while in IDLE -> no writes.
